id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the pipelined MIPS core.
- Captures the control bundle produced by the main decoder, plus the register-file operands and immediates, into the ID/EX pipeline register.
- Contains the hazard detector for the ID/EX boundary. It detects load-use hazards and ID-stage branch/JR operand hazards, drives stallF/stallD, and inserts bubbles into EX.
- Decodes the destination register (writeregE) for downstream forwarding and writeback.

Parameters:
- WIDTH, 32, datapath width of operands, immediate and PC+4.
- RA_REG, 31, register index written when regdstE = 2'b10 (JAL).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- freeze  in  1  global hold (memory wait); highest priority.
- flushE  in  1  external flush of EX (e.g. exception); forces a bubble.
- regwriteD, alusrcD, memwriteD, memtoregD, byteMD  in  1 each  decoder controls.
- regdstD, aluopD, srcaselectorD, wd3selectorD  in  2 each  decoder controls.
- branchD, branchneD, jumprD  in  1 each  ID-resolved control transfer flags; used only for hazard check, not registered.
- rd1D, rd2D, signimmD, pcplus4D  in  WIDTH each  operands.
- rsD, rtD, rdD  in  5 each  register indices.
- writeregM  in  5  destination register of the MEM stage.
- memtoregM  in  1  MEM-stage load flag.
- Registered E-stage copies of every control and data input above: same widths, suffix E.
- validE  out  1  EX holds a real instruction, not a bubble.
- writeregE  out  5  decoded destination register.
- stallF, stallD  out  1 each  hold PC and IF/ID.
- bubbles  out  16  saturating count of hazard-inserted bubbles.

Behaviour:
- Reset (asynchronous, reset_n low):
  - All E outputs go to 0, including validE = 0.
  - bubbles = 0.
  - stallF = stallD = 0 while in reset.
  - Reset mid-operation discards the EX contents immediately.
- writeregE is combinational from the registered fields:
  - regdstE 00 -> rtE; 01 -> rdE; 10 -> RA_REG; 11 -> 0.
- lwstall (combinational) = memtoregE & validE & ((rtE == rsD & rsD != 0) | (rtE == rtD & rtD != 0)).
- brstall (combinational) = (branchD | branchneD | jumprD) & (A | B), where:
  - A = regwriteE & validE & (writeregE != 0) & (writeregE matches rsD, or rtD for branches only).
  - B = memtoregM & (writeregM != 0) & (writeregM matches rsD, or rtD for branches only).
  - JR checks rsD only.
- hazard = lwstall | brstall.
- stallF = stallD = hazard | freeze.
- Register update priority on each rising edge:
  1. freeze = 1: all E registers and bubbles hold. freeze overrides flushE and hazard.
  2. flushE = 1 or hazard = 1: all E control bits, including validE, are cleared to 0. Data fields take don't-care values (implement as hold). bubbles increments only when hazard is the cause.
  3. Otherwise: E registers load from D; validE = 1.
- bubbles saturates at 16'hFFFF and does not wrap.
- A bubble never writes a register or memory, since every control bit is 0.
- Latency: one cycle from D inputs to E outputs. A load-use hazard costs exactly one bubble. A branch dependent on an EX ALU result costs one bubble. A branch dependent on an EX load costs two bubbles: one for the EX load, then one more while the load is in MEM.
- Register index 0 never causes a stall.
- Simultaneous flushE and hazard: bubble inserted, bubbles increments.

Test Plan:
- Reset: hold reset_n low 2 cycles with nonzero inputs -> all E outputs 0, validE = 0, bubbles = 0. Release with an ADD (regdstD = 01, rdD = 8) -> next cycle validE = 1, writeregE = 8.
- Load-use: LW to $t0 (rtE = 8, memtoregE = 1), then ADD with rsD = 8 -> stallF = stallD = 1 for one cycle, EX bubble (regwriteE = 0, validE = 0), bubbles = 1. The following cycle loads the ADD.
- Zero register: LW writing $0 followed by a consumer with rsD = 0 -> no stall, bubbles unchanged.
- BEQ after LW: LW rt = 9, then BEQ with rsD = 9 -> two consecutive stall cycles (EX lwstall+brstall, then MEM brstall via writeregM = 9, memtoregM = 1), bubbles = 2.
- JAL decode: regdstD = 10 -> writeregE = 31. JR with rsD = 31 while JAL is in EX with regwriteE = 1 -> one stall.
- Freeze during hazard: freeze = 1 with lwstall active for 3 cycles -> E registers unchanged, bubbles unchanged, stalls asserted. After freeze drops, one bubble is inserted and bubbles increments once. Preload bubbles = FFFF plus one more hazard -> stays FFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core.
// Holds the decoded control bundle and operands for EX, detects load-use and
// ID-resolved branch/JR operand hazards, and counts the bubbles it inserts.
module id_ex_stage #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RA_REG = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             freeze,
  input  logic             flushE,

  input  logic             regwriteD,
  input  logic             alusrcD,
  input  logic             memwriteD,
  input  logic             memtoregD,
  input  logic             byteMD,
  input  logic [1:0]       regdstD,
  input  logic [1:0]       aluopD,
  input  logic [1:0]       srcaselectorD,
  input  logic [1:0]       wd3selectorD,
  input  logic             branchD,
  input  logic             branchneD,
  input  logic             jumprD,
  input  logic [WIDTH-1:0] rd1D,
  input  logic [WIDTH-1:0] rd2D,
  input  logic [WIDTH-1:0] signimmD,
  input  logic [WIDTH-1:0] pcplus4D,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rdD,
  input  logic [4:0]       writeregM,
  input  logic             memtoregM,

  output logic             regwriteE,
  output logic             alusrcE,
  output logic             memwriteE,
  output logic             memtoregE,
  output logic             byteME,
  output logic [1:0]       regdstE,
  output logic [1:0]       aluopE,
  output logic [1:0]       srcaselectorE,
  output logic [1:0]       wd3selectorE,
  output logic [WIDTH-1:0] rd1E,
  output logic [WIDTH-1:0] rd2E,
  output logic [WIDTH-1:0] signimmE,
  output logic [WIDTH-1:0] pcplus4E,
  output logic [4:0]       rsE,
  output logic [4:0]       rtE,
  output logic [4:0]       rdE,
  output logic             validE,
  output logic [4:0]       writeregE,
  output logic             stallF,
  output logic             stallD,
  output logic [15:0]      bubbles
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [REG_W-1:0] RA_IDX  = REG_W'(RA_REG);

  // Control flops (cleared on a bubble)
  logic             regwrite_q, regwrite_d;
  logic             alusrc_q, alusrc_d;
  logic             memwrite_q, memwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic             bytem_q, bytem_d;
  logic [1:0]       regdst_q, regdst_d;
  logic [1:0]       aluop_q, aluop_d;
  logic [1:0]       srcasel_q, srcasel_d;
  logic [1:0]       wd3sel_q, wd3sel_d;
  logic             valid_q, valid_d;

  // Data flops (held on a bubble)
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;
  logic [WIDTH-1:0] signimm_q, signimm_d;
  logic [WIDTH-1:0] pcplus4_q, pcplus4_d;
  logic [REG_W-1:0] rs_q, rs_d;
  logic [REG_W-1:0] rt_q, rt_d;
  logic [REG_W-1:0] rd_q, rd_d;

  logic [CNT_W-1:0] bubbles_q, bubbles_d;

  logic [REG_W-1:0] writereg_c;
  logic             ctl_xfer_c;
  logic             uses_rt_c;
  logic             lwstall_c;
  logic             ex_hit_c;
  logic             mem_hit_c;
  logic             brstall_c;
  logic             hazard_c;

  // Destination register of the instruction currently in EX
  always_comb begin
    writereg_c = '0;
    unique case (regdst_q)
      2'b00:   writereg_c = rt_q;
      2'b01:   writereg_c = rd_q;
      2'b10:   writereg_c = RA_IDX;
      default: writereg_c = '0;
    endcase
  end

  // Hazard detection: load-use against EX, branch/JR operands against EX and MEM
  always_comb begin
    ctl_xfer_c = branchD | branchneD | jumprD;
    uses_rt_c  = branchD | branchneD;

    lwstall_c  = memtoreg_q & valid_q &
                 (((rt_q == rsD) && (rsD != '0)) || ((rt_q == rtD) && (rtD != '0)));

    ex_hit_c   = regwrite_q & valid_q & (writereg_c != '0) &
                 ((writereg_c == rsD) || (uses_rt_c && (writereg_c == rtD)));

    mem_hit_c  = memtoregM & (writeregM != '0) &
                 ((writeregM == rsD) || (uses_rt_c && (writeregM == rtD)));

    brstall_c  = ctl_xfer_c & (ex_hit_c | mem_hit_c);
    hazard_c   = lwstall_c | brstall_c;
  end

  // Next-state selection: freeze holds, flush/hazard inserts a bubble, else advance
  always_comb begin
    regwrite_d = regwrite_q;
    alusrc_d   = alusrc_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    bytem_d    = bytem_q;
    regdst_d   = regdst_q;
    aluop_d    = aluop_q;
    srcasel_d  = srcasel_q;
    wd3sel_d   = wd3sel_q;
    valid_d    = valid_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    signimm_d  = signimm_q;
    pcplus4_d  = pcplus4_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    bubbles_d  = bubbles_q;

    if (freeze) begin
      // everything holds
    end else if (flushE || hazard_c) begin
      regwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      bytem_d    = 1'b0;
      regdst_d   = 2'b00;
      aluop_d    = 2'b00;
      srcasel_d  = 2'b00;
      wd3sel_d   = 2'b00;
      valid_d    = 1'b0;
      if (hazard_c && (bubbles_q != CNT_MAX)) begin
        bubbles_d = bubbles_q + CNT_W'(1);
      end
    end else begin
      regwrite_d = regwriteD;
      alusrc_d   = alusrcD;
      memwrite_d = memwriteD;
      memtoreg_d = memtoregD;
      bytem_d    = byteMD;
      regdst_d   = regdstD;
      aluop_d    = aluopD;
      srcasel_d  = srcaselectorD;
      wd3sel_d   = wd3selectorD;
      valid_d    = 1'b1;
      rd1_d      = rd1D;
      rd2_d      = rd2D;
      signimm_d  = signimmD;
      pcplus4_d  = pcplus4D;
      rs_d       = rsD;
      rt_d       = rtD;
      rd_d       = rdD;
    end
  end

  // ID/EX pipeline register and bubble counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      bytem_q    <= 1'b0;
      regdst_q   <= 2'b00;
      aluop_q    <= 2'b00;
      srcasel_q  <= 2'b00;
      wd3sel_q   <= 2'b00;
      valid_q    <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      signimm_q  <= '0;
      pcplus4_q  <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      bubbles_q  <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      alusrc_q   <= alusrc_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      bytem_q    <= bytem_d;
      regdst_q   <= regdst_d;
      aluop_q    <= aluop_d;
      srcasel_q  <= srcasel_d;
      wd3sel_q   <= wd3sel_d;
      valid_q    <= valid_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      signimm_q  <= signimm_d;
      pcplus4_q  <= pcplus4_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      bubbles_q  <= bubbles_d;
    end
  end

  // Output mapping; stalls are suppressed while reset is held
  assign regwriteE     = regwrite_q;
  assign alusrcE       = alusrc_q;
  assign memwriteE     = memwrite_q;
  assign memtoregE     = memtoreg_q;
  assign byteME        = bytem_q;
  assign regdstE       = regdst_q;
  assign aluopE        = aluop_q;
  assign srcaselectorE = srcasel_q;
  assign wd3selectorE  = wd3sel_q;
  assign rd1E          = rd1_q;
  assign rd2E          = rd2_q;
  assign signimmE      = signimm_q;
  assign pcplus4E      = pcplus4_q;
  assign rsE           = rs_q;
  assign rtE           = rt_q;
  assign rdE           = rd_q;
  assign validE        = valid_q;
  assign writeregE     = writereg_c;
  assign bubbles       = bubbles_q;
  assign stallF        = (hazard_c | freeze) & reset_n;
  assign stallD        = (hazard_c | freeze) & reset_n;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed hazard scenarios, randomized traffic and
// bubble-counter saturation, checked against an instruction-level model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        regwrite, alusrc, memwrite, memtoreg, bytem;
    logic [1:0]  regdst, aluop, srcsel, wd3sel;
    logic        branch, branchne, jumpr;
    logic [31:0] rd1, rd2, signimm, pcplus4;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  logic clk, reset_n, freeze, flushE, memtoregM;
  logic [4:0] writeregM;
  instr_t d;

  logic        regwriteE, alusrcE, memwriteE, memtoregE, byteME, validE;
  logic [1:0]  regdstE, aluopE, srcaselectorE, wd3selectorE;
  logic [31:0] rd1E, rd2E, signimmE, pcplus4E;
  logic [4:0]  rsE, rtE, rdE, writeregE;
  logic        stallF, stallD;
  logic [15:0] bubbles;

  // Model state: the instruction in EX (or a bubble), and the bubble count
  instr_t m;
  bit     m_valid;
  int     m_bub;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.WIDTH(32), .RA_REG(31)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze), .flushE(flushE),
    .regwriteD(d.regwrite), .alusrcD(d.alusrc), .memwriteD(d.memwrite),
    .memtoregD(d.memtoreg), .byteMD(d.bytem), .regdstD(d.regdst),
    .aluopD(d.aluop), .srcaselectorD(d.srcsel), .wd3selectorD(d.wd3sel),
    .branchD(d.branch), .branchneD(d.branchne), .jumprD(d.jumpr),
    .rd1D(d.rd1), .rd2D(d.rd2), .signimmD(d.signimm), .pcplus4D(d.pcplus4),
    .rsD(d.rs), .rtD(d.rt), .rdD(d.rd),
    .writeregM(writeregM), .memtoregM(memtoregM),
    .regwriteE(regwriteE), .alusrcE(alusrcE), .memwriteE(memwriteE),
    .memtoregE(memtoregE), .byteME(byteME), .regdstE(regdstE),
    .aluopE(aluopE), .srcaselectorE(srcaselectorE), .wd3selectorE(wd3selectorE),
    .rd1E(rd1E), .rd2E(rd2E), .signimmE(signimmE), .pcplus4E(pcplus4E),
    .rsE(rsE), .rtE(rtE), .rdE(rdE), .validE(validE), .writeregE(writeregE),
    .stallF(stallF), .stallD(stallD), .bubbles(bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register the instruction in EX will write (0 = none by field choice)
  function automatic logic [4:0] m_dest();
    case (m.regdst)
      2'b00:   return m.rt;
      2'b01:   return m.rd;
      2'b10:   return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  // Does the instruction in ID have to wait?
  function automatic bit m_hazard();
    logic [4:0] srcs[$];
    bit is_br;
    is_br = d.branch || d.branchne;
    // load in EX feeding either source field of the next instruction
    if (m_valid && m.memtoreg &&
        ((d.rs != 0 && d.rs == m.rt) || (d.rt != 0 && d.rt == m.rt)))
      return 1;
    if (!(is_br || d.jumpr)) return 0;
    srcs.push_back(d.rs);
    if (is_br) srcs.push_back(d.rt);
    foreach (srcs[i]) begin
      if (srcs[i] == 0) continue;
      if (m_valid && m.regwrite && srcs[i] == m_dest()) return 1;
      if (memtoregM && srcs[i] == writeregM) return 1;
    end
    return 0;
  endfunction

  // Advance the model by one clock edge
  task automatic m_clock(input bit hz);
    if (freeze) begin
    end else if (flushE || hz) begin
      m.regwrite = 0; m.alusrc = 0; m.memwrite = 0; m.memtoreg = 0; m.bytem = 0;
      m.regdst = 0; m.aluop = 0; m.srcsel = 0; m.wd3sel = 0;
      m_valid = 0;
      if (hz && m_bub < 65535) m_bub++;
    end else begin
      m = d;
      m_valid = 1;
    end
  endtask

  task automatic m_reset();
    m = '0;
    m_valid = 0;
    m_bub = 0;
  endtask

  task automatic check_e();
    chk("regwriteE", 32'(regwriteE), 32'(m.regwrite));
    chk("alusrcE", 32'(alusrcE), 32'(m.alusrc));
    chk("memwriteE", 32'(memwriteE), 32'(m.memwrite));
    chk("memtoregE", 32'(memtoregE), 32'(m.memtoreg));
    chk("byteME", 32'(byteME), 32'(m.bytem));
    chk("regdstE", 32'(regdstE), 32'(m.regdst));
    chk("aluopE", 32'(aluopE), 32'(m.aluop));
    chk("srcaselectorE", 32'(srcaselectorE), 32'(m.srcsel));
    chk("wd3selectorE", 32'(wd3selectorE), 32'(m.wd3sel));
    chk("rd1E", rd1E, m.rd1);
    chk("rd2E", rd2E, m.rd2);
    chk("signimmE", signimmE, m.signimm);
    chk("pcplus4E", pcplus4E, m.pcplus4);
    chk("rsE", 32'(rsE), 32'(m.rs));
    chk("rtE", 32'(rtE), 32'(m.rt));
    chk("rdE", 32'(rdE), 32'(m.rd));
    chk("validE", 32'(validE), 32'(m_valid));
    chk("writeregE", 32'(writeregE), 32'(m_dest()));
    chk("bubbles", 32'(bubbles), 32'(m_bub));
  endtask

  // One cycle: inputs already driven; check stalls, clock, check EX state
  task automatic step();
    bit hz;
    #1;
    hz = m_hazard();
    chk("stallF", 32'(stallF), 32'(hz || freeze));
    chk("stallD", 32'(stallD), 32'(hz || freeze));
    @(posedge clk);
    m_clock(hz);
    #1;
    check_e();
  endtask

  function automatic instr_t rnd_data(input instr_t i);
    instr_t r = i;
    r.rd1 = $urandom(); r.rd2 = $urandom();
    r.signimm = $urandom(); r.pcplus4 = $urandom();
    return r;
  endfunction

  function automatic instr_t alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    instr_t r = '0;
    r.regwrite = 1; r.regdst = 2'b01; r.aluop = 2'b10;
    r.rs = rs; r.rt = rt; r.rd = rd;
    return rnd_data(r);
  endfunction

  function automatic instr_t lw(input logic [4:0] rs, input logic [4:0] rt);
    instr_t r = '0;
    r.regwrite = 1; r.alusrc = 1; r.memtoreg = 1; r.wd3sel = 2'b01;
    r.rs = rs; r.rt = rt; r.rd = 5'd0;
    return rnd_data(r);
  endfunction

  function automatic instr_t rnd_instr();
    instr_t r;
    int k;
    r = rnd_data('0);
    r.regwrite = 1'($urandom_range(0, 1));
    r.alusrc   = 1'($urandom_range(0, 1));
    r.memwrite = 1'($urandom_range(0, 1));
    r.memtoreg = 1'($urandom_range(0, 1));
    r.bytem    = 1'($urandom_range(0, 1));
    r.regdst   = 2'($urandom_range(0, 3));
    r.aluop    = 2'($urandom_range(0, 3));
    r.srcsel   = 2'($urandom_range(0, 3));
    r.wd3sel   = 2'($urandom_range(0, 3));
    r.rs = 5'($urandom_range(0, 7));
    r.rt = 5'($urandom_range(0, 7));
    r.rd = 5'($urandom_range(0, 7));
    k = int'($urandom_range(0, 5));
    r.branch   = (k == 0);
    r.branchne = (k == 1);
    r.jumpr    = (k == 2);
    if (k == 2 && $urandom_range(0, 1) == 1) r.rs = 5'd31;
    return r;
  endfunction

  initial begin
    // Reset held with nonzero inputs that would otherwise stall
    reset_n = 0; freeze = 0; flushE = 0;
    d = alu(5'd5, 5'd6, 5'd7);
    d.branch = 1;
    writeregM = 5'd5; memtoregM = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_validE", 32'(validE), 32'd0);
    chk("rst_regwriteE", 32'(regwriteE), 32'd0);
    chk("rst_rd1E", rd1E, 32'd0);
    chk("rst_bubbles", 32'(bubbles), 32'd0);
    chk("rst_stallF", 32'(stallF), 32'd0);
    chk("rst_stallD", 32'(stallD), 32'd0);
    check_e();

    // Release with ADD rd=8
    reset_n = 1; writeregM = 0; memtoregM = 0;
    d = alu(5'd1, 5'd2, 5'd8);
    step();
    chk("rel_valid", 32'(validE), 32'd1);
    chk("rel_wreg", 32'(writeregE), 32'd8);

    // Load-use: one bubble then the consumer loads
    d = lw(5'd3, 5'd8); step();
    d = alu(5'd8, 5'd2, 5'd10); step();
    chk("lu_valid", 32'(validE), 32'd0);
    chk("lu_bub", 32'(bubbles), 32'd1);
    step();
    chk("lu_load", 32'(validE), 32'd1);

    // Load to $0 followed by a $0 reader: no stall
    d = lw(5'd1, 5'd0); step();
    d = alu(5'd0, 5'd4, 5'd11); step();
    chk("zero_bub", 32'(bubbles), 32'd1);

    // BEQ after LW: EX stall, then MEM stall
    d = lw(5'd1, 5'd9); step();
    d = '0; d.branch = 1; d.aluop = 2'b01; d.rs = 5'd9; d.rt = 5'd0;
    step();
    writeregM = 5'd9; memtoregM = 1; step();
    chk("beq_bub", 32'(bubbles), 32'd3);
    writeregM = 5'd0; memtoregM = 0; step();

    // JAL then dependent JR
    d = alu(5'd2, 5'd3, 5'd4); d.regdst = 2'b10; d.wd3sel = 2'b10; step();
    chk("jal_wreg", 32'(writeregE), 32'd31);
    d = '0; d.jumpr = 1; d.rs = 5'd31; step();
    chk("jr_bub", 32'(bubbles), 32'd4);
    step();

    // Freeze over an active load-use hazard
    d = lw(5'd1, 5'd8); step();
    d = alu(5'd8, 5'd3, 5'd12); freeze = 1;
    repeat (3) step();
    chk("frz_bub", 32'(bubbles), 32'd4);
    freeze = 0; step();
    chk("frz_rel_bub", 32'(bubbles), 32'd5);
    step();

    // Flush coinciding with a hazard counts; a plain flush does not
    d = lw(5'd1, 5'd7); step();
    d = alu(5'd7, 5'd3, 5'd13); flushE = 1; step();
    chk("flh_bub", 32'(bubbles), 32'd6);
    flushE = 0; step();
    d = alu(5'd1, 5'd2, 5'd3); flushE = 1; step();
    chk("flush_bub", 32'(bubbles), 32'd6);
    flushE = 0; step();

    // Asynchronous reset mid-operation
    reset_n = 0; #1;
    m_reset();
    chk("async_valid", 32'(validE), 32'd0);
    chk("async_bub", 32'(bubbles), 32'd0);
    chk("async_stall", 32'(stallF), 32'd0);
    @(posedge clk); #1;
    reset_n = 1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      d = rnd_instr();
      freeze = ($urandom_range(0, 7) == 0);
      flushE = ($urandom_range(0, 7) == 0);
      memtoregM = 1'($urandom_range(0, 1));
      writeregM = 5'($urandom_range(0, 7));
      step();
    end

    // Persistent MEM-load branch hazard drives the counter into saturation
    freeze = 0; flushE = 0;
    d = '0; d.branch = 1; d.rs = 5'd5;
    writeregM = 5'd5; memtoregM = 1;
    for (int i = 0; i < 65540; i++) begin
      bit hz;
      hz = m_hazard();
      @(posedge clk);
      m_clock(hz);
    end
    #1;
    chk("sat_bub", 32'(bubbles), 32'h0000_FFFF);
    step();
    chk("sat_hold", 32'(bubbles), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
